// File: rtl/dp_types_pkg.sv
// Shared datapath types: branch-predictor counter encoding and BTB entry layout.
package dp_types_pkg;

    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = 32 - BP_IDX_W - 2;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_cnt_t;

    // Tag field is sized for the default index width; wider indexes leave upper tag bits zero.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        bp_cnt_t             cnt;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state; force_st_i pins the result to strong-taken.
module bp_sat_counter
    import dp_types_pkg::*;
(
    input  bp_cnt_t cur_i,
    input  logic    taken_i,
    input  logic    force_st_i,
    output bp_cnt_t next_o
);

    always_comb begin
        next_o = cur_i;
        if (force_st_i) begin
            next_o = BP_ST;
        end else if (taken_i) begin
            if (cur_i != BP_ST) next_o = bp_cnt_t'(cur_i + 2'b01);
        end else begin
            if (cur_i != BP_SNT) next_o = bp_cnt_t'(cur_i - 2'b01);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, MEM-stage update.
// Define BP_STATS_EN to add branch / mispredict statistics counters.
module branch_predictor
    import dp_types_pkg::*;
#(
    parameter int         IDX_W    = BP_IDX_W,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic        upd_uncond,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic        freeze
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    btb_entry_t tbl_q [ENTRIES];

    // Lookup: reads registered table contents only, so a same-cycle update is not bypassed.
    logic [IDX_W-1:0]    lk_idx;
    logic [BP_TAG_W-1:0] lk_tag;
    btb_entry_t          lk_e;
    logic                lk_hit;

    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = BP_TAG_W'(if_pc[31:IDX_W+2]);
    assign lk_e        = tbl_q[lk_idx];
    assign lk_hit      = lk_e.valid && (lk_e.tag == lk_tag);
    assign pred_taken  = lk_hit && lk_e.cnt[1];
    assign pred_target = pred_taken ? lk_e.target : (if_pc + 32'd4);

    logic [IDX_W-1:0]    u_idx;
    logic [BP_TAG_W-1:0] u_tag;
    btb_entry_t          u_e;
    logic                u_hit;
    logic                u_accept;
    logic                u_we;
    bp_cnt_t             u_cnt_nxt;
    btb_entry_t          ent_d;

    assign u_idx    = upd_pc[IDX_W+1:2];
    assign u_tag    = BP_TAG_W'(upd_pc[31:IDX_W+2]);
    assign u_e      = tbl_q[u_idx];
    assign u_hit    = u_e.valid && (u_e.tag == u_tag);
    assign u_accept = upd_valid && !freeze;
    // A not-taken conditional that misses leaves the resident entry alone.
    assign u_we     = u_accept && (u_hit || upd_taken || upd_uncond);

    bp_sat_counter u_sat (
        .cur_i      (u_e.cnt),
        .taken_i    (upd_taken),
        .force_st_i (upd_uncond),
        .next_o     (u_cnt_nxt)
    );

    always_comb begin
        ent_d = u_e;
        if (u_hit) begin
            ent_d.cnt = u_cnt_nxt;
            if (upd_taken || upd_uncond) ent_d.target = upd_target;
        end else begin
            ent_d.valid  = 1'b1;
            ent_d.tag    = u_tag;
            ent_d.target = upd_target;
            ent_d.cnt    = upd_uncond ? BP_ST : BP_WT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= '0;
                tbl_q[i].cnt    <= bp_cnt_t'(CNT_INIT);
            end
        end else if (u_we) begin
            tbl_q[u_idx] <= ent_d;
        end
    end

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

`ifdef BP_STATS_EN
    logic [31:0] br_q, br_d;
    logic [31:0] mp_q, mp_d;

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (u_accept) begin
            br_d = br_q + 32'd1;
            if (upd_taken != upd_pred_taken) mp_d = mp_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end

    assign stat_branches = br_q;
    assign stat_mispred  = mp_q;
`else
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (stats checks compile in with BP_STATS_EN).
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_uncond;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        freeze;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int n_chk = 0;
    int n_fail = 0;

    branch_predictor #(.IDX_W(4), .CNT_INIT(2'b01)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_uncond     (upd_uncond),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .freeze         (freeze)
`ifdef BP_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tg);
        if_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        chk({tag, "_target"}, pred_target, exp_tg);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic unc,
                           input logic [31:0] tgt, input logic ptk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_uncond     = unc;
        upd_target     = tgt;
        upd_pred_taken = ptk;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic unc,
                       input logic [31:0] tgt, input logic ptk);
        set_upd(pc, tk, unc, tgt, ptk);
        @(posedge CLK);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; if_pc = '0; freeze = 1'b0;
        upd_valid = 1'b0; upd_uncond = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        do_reset();

        look("rst_0x40", 32'h40, 1'b0, 32'h44);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Same-cycle lookup and allocating update: old contents seen this cycle
        if_pc = 32'h40;
        set_upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b0);
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        @(posedge CLK);
        #1;
        upd_valid = 1'b0;
        look("alloc_0x40", 32'h40, 1'b1, 32'h80);

        // 10 -> 01 -> 00 -> 00 (clamp) -> 01 -> 10
        upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        look("nt1", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0);
        look("nt2", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0);
        look("nt3_clamp", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 1'b0, 32'h84, 1'b0);
        look("t1_from00", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 1'b0, 32'h84, 1'b0);
        look("t2_newtgt", 32'h40, 1'b1, 32'h84);

        // Aliasing into index 0
        upd(32'h440, 1'b1, 1'b0, 32'h900, 1'b0);
        look("alias_old", 32'h40, 1'b0, 32'h44);
        look("alias_new", 32'h440, 1'b1, 32'h900);

        // Not-taken miss must not disturb the resident entry
        upd(32'h80, 1'b0, 1'b0, 32'hABC, 1'b0);
        look("miss_nt", 32'h80, 1'b0, 32'h84);
        look("miss_nt_keep", 32'h440, 1'b1, 32'h900);

        // JAL allocates strong-taken
        upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
        look("jal", 32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b1);
        look("jal_nt1", 32'h100, 1'b1, 32'h200);
        freeze = 1'b1;
        upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b1);
        look("frozen", 32'h100, 1'b1, 32'h200);
        freeze = 1'b0;
        upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b1);
        look("jal_nt2", 32'h100, 1'b0, 32'h104);

        // Unconditional hit forces 11 and rewrites target
        upd(32'h100, 1'b1, 1'b1, 32'h300, 1'b0);
        look("jal_hit", 32'h100, 1'b1, 32'h300);
        upd(32'h100, 1'b0, 1'b0, 32'h300, 1'b1);
        look("jal_hit_nt", 32'h100, 1'b1, 32'h300);

        // Reset wins over a concurrent update
        set_upd(32'h200, 1'b1, 1'b1, 32'h400, 1'b0);
        do_reset();
        upd_valid = 1'b0;
        look("rst_upd_0x200", 32'h200, 1'b0, 32'h204);
        look("rst_clr_0x100", 32'h100, 1'b0, 32'h104);

`ifdef BP_STATS_EN
        chk("stat_br_rst", stat_branches, 32'd0);
        chk("stat_mp_rst", stat_mispred, 32'd0);
        upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b0);
        upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b1);
        upd(32'h80, 1'b0, 1'b0, 32'h90, 1'b0);
        upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b1);
        chk("stat_br_5", stat_branches, 32'd5);
        chk("stat_mp_2", stat_mispred, 32'd2);
        freeze = 1'b1;
        upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        freeze = 1'b0;
        chk("stat_br_frz", stat_branches, 32'd5);
        chk("stat_mp_frz", stat_mispred, 32'd2);
        do_reset();
        chk("stat_br_clr", stat_branches, 32'd0);
        chk("stat_mp_clr", stat_mispred, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
